// File: rtl/relu_backprop.sv
`default_nettype none
// ============================================================================
// Module   : relu_backprop
// Purpose  : ReLU backward pass. Each forward activation pushes one mask bit
//            (1 when the activation is strictly positive) into a FIFO. Each
//            upstream gradient pops the oldest mask bit and produces the
//            masked gradient through a one-deep registered output stage.
// Revision : 1.0 - initial release
//
// Parameters
//   BITWIDTH : width of signed activation / gradient words
//   DEPTH    : mask FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i         in   1            clock, rising edge
//   rst_n_i       in   1            asynchronous active-low reset
//   clear_i       in   1            synchronous flush of FIFO and output stage
//   fwd_valid_i   in   1            forward activation valid
//   fwd_ready_o   out  1            mask FIFO can accept an activation
//   fwd_data_i    in   BITWIDTH     signed pre-ReLU activation
//   grad_valid_i  in   1            upstream gradient valid
//   grad_ready_o  out  1            gradient accepted this cycle
//   grad_data_i   in   BITWIDTH     signed upstream gradient
//   out_valid_o   out  1            out_data_o holds a result
//   out_ready_i   in   1            downstream accepts the result
//   out_data_o    out  BITWIDTH     signed masked gradient
//   mask_count_o  out  clog2(D)+1   number of stored mask bits
//
// Build option
//   RELU_BACKPROP_LEAKY_EN : when defined, mask-0 entries pass the gradient
//                            arithmetically shifted right by 3 (slope 1/8)
//                            instead of zero.
// ============================================================================
module relu_backprop #(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       fwd_valid_i,
  output logic                       fwd_ready_o,
  input  logic signed [BITWIDTH-1:0] fwd_data_i,
  input  logic                       grad_valid_i,
  output logic                       grad_ready_o,
  input  logic signed [BITWIDTH-1:0] grad_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic signed [BITWIDTH-1:0] out_data_o,
  output logic [$clog2(DEPTH):0]     mask_count_o
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  // Mask storage: one bit per pending activation.
  logic [DEPTH-1:0]          mask_mem;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;

  logic                      push;
  logic                      pop;
  logic                      act_positive;
  logic                      head_mask;
  logic signed [BITWIDTH-1:0] masked_grad;
  logic signed [BITWIDTH-1:0] blocked_grad;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never lets a push slip into a full FIFO.
  assign fwd_ready_o  = (count < DEPTH_CNT);
  // The output stage may take a new result when empty or draining this cycle.
  assign grad_ready_o = (count != '0) && (!out_valid_o || out_ready_i);

  assign push = fwd_valid_i && fwd_ready_o;
  assign pop  = grad_valid_i && grad_ready_o;

  // Strictly positive: sign bit clear and not zero.
  assign act_positive = !fwd_data_i[BITWIDTH-1] && (|fwd_data_i);
  assign head_mask    = mask_mem[rd_ptr];

`ifdef RELU_BACKPROP_LEAKY_EN
  assign blocked_grad = grad_data_i >>> 3;
`else
  assign blocked_grad = '0;
`endif

  assign masked_grad = head_mask ? grad_data_i : blocked_grad;

  // Mask bits need no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mask_mem[wr_ptr] <= act_positive;
    end
  end

  // Pointers and occupancy. Pointer width equals log2(DEPTH), so the natural
  // binary rollover is the modulo-DEPTH wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered output stage: loads on every gradient transfer, otherwise
  // holds until the downstream takes the result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (pop) begin
      out_valid_o <= 1'b1;
      out_data_o  <= masked_grad;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign mask_count_o = count;

endmodule
`default_nettype wire

// File: tb/tb_relu_backprop.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_backprop
// Purpose  : Directed, table-driven bench for relu_backprop (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_backprop;

  logic              clk_i;
  logic              rst_n_i;
  logic              clear_i;
  logic              fwd_valid_i;
  logic              fwd_ready_o;
  logic signed [7:0] fwd_data_i;
  logic              grad_valid_i;
  logic              grad_ready_o;
  logic signed [7:0] grad_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic signed [7:0] out_data_o;
  logic [4:0]        mask_count_o;

  int checks   = 0;
  int failures = 0;

  relu_backprop #(.BITWIDTH(8), .DEPTH(16)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (clear_i),
    .fwd_valid_i  (fwd_valid_i),
    .fwd_ready_o  (fwd_ready_o),
    .fwd_data_i   (fwd_data_i),
    .grad_valid_i (grad_valid_i),
    .grad_ready_o (grad_ready_o),
    .grad_data_i  (grad_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .mask_count_o (mask_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic signed [7:0] act;
    logic signed [7:0] grad;
    logic signed [7:0] exp_plain;
    logic signed [7:0] exp_leaky;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick(input logic signed [7:0] plain, input logic signed [7:0] leaky);
`ifdef RELU_BACKPROP_LEAKY_EN
    return int'(leaky);
`else
    return int'(plain);
`endif
  endfunction

  task automatic push(input logic signed [7:0] act);
    fwd_valid_i = 1'b1;
    fwd_data_i  = act;
    check("push_ready", int'(fwd_ready_o), 1);
    tick();
    fwd_valid_i = 1'b0;
  endtask

  initial begin
    // Activation, gradient, expected (leaky off), expected (leaky on).
    vecs[0] = '{ 8'sd5,    8'sd10,   8'sd10,   8'sd10  };
    vecs[1] = '{-8'sd3,    8'sd10,   8'sd0,    8'sd1   };
    vecs[2] = '{ 8'sd0,    8'sd10,   8'sd0,    8'sd1   };
    vecs[3] = '{ 8'sd127,  8'sd10,   8'sd10,   8'sd10  };
    vecs[4] = '{-8'sd128, -8'sd7,    8'sd0,   -8'sd1   };
    vecs[5] = '{ 8'sd1,   -8'sd100, -8'sd100, -8'sd100 };
    vecs[6] = '{-8'sd1,    8'sd50,   8'sd0,    8'sd6   };
    vecs[7] = '{ 8'sd64,  -8'sd128, -8'sd128, -8'sd128 };
    vecs[8] = '{-8'sd4,   -8'sd64,   8'sd0,   -8'sd8   };
    vecs[9] = '{-8'sd4,    8'sd40,   8'sd0,    8'sd5   };

    rst_n_i      = 1'b0;
    clear_i      = 1'b0;
    fwd_valid_i  = 1'b0;
    fwd_data_i   = '0;
    grad_valid_i = 1'b0;
    grad_data_i  = '0;
    out_ready_i  = 1'b1;

    // ---- reset state ----
    #3;
    check("rst_fwd_ready",  int'(fwd_ready_o), 1);
    check("rst_grad_ready", int'(grad_ready_o), 0);
    check("rst_count",      int'(mask_count_o), 0);
    check("rst_out_valid",  int'(out_valid_o), 0);
    check("rst_out_data",   int'(out_data_o), 0);
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();
    check("post_rst_fwd_ready",  int'(fwd_ready_o), 1);
    check("post_rst_grad_ready", int'(grad_ready_o), 0);

    // ---- empty FIFO refuses gradients ----
    grad_valid_i = 1'b1;
    grad_data_i  = 8'sd99;
    for (int i = 0; i < 3; i++) begin
      check("empty_grad_ready", int'(grad_ready_o), 0);
      tick();
      check("empty_out_valid", int'(out_valid_o), 0);
    end
    grad_valid_i = 1'b0;

    // ---- table: push all activations, then stream gradients ----
    for (int i = 0; i < 10; i++) push(vecs[i].act);
    check("tbl_count_full", int'(mask_count_o), 10);
    for (int i = 0; i < 10; i++) begin
      grad_valid_i = 1'b1;
      grad_data_i  = vecs[i].grad;
      check("tbl_grad_ready", int'(grad_ready_o), 1);
      tick();
      check("tbl_out_valid", int'(out_valid_o), 1);
      check($sformatf("tbl_out_data[%0d]", i), int'(out_data_o),
            pick(vecs[i].exp_plain, vecs[i].exp_leaky));
    end
    grad_valid_i = 1'b0;
    tick();
    check("tbl_drained_valid", int'(out_valid_o), 0);
    check("tbl_drained_count", int'(mask_count_o), 0);

    // ---- fill to DEPTH, then push+pop at full ----
    for (int i = 0; i < 16; i++) push((i % 2 == 0) ? 8'sd3 : -8'sd3);
    check("full_fwd_ready", int'(fwd_ready_o), 0);
    check("full_count", int'(mask_count_o), 16);
    fwd_valid_i  = 1'b1;
    fwd_data_i   = 8'sd9;
    grad_valid_i = 1'b1;
    grad_data_i  = 8'sd20;
    tick();
    check("full_pushpop_count", int'(mask_count_o), 15);
    check("full_pop_data", int'(out_data_o), 20);
    check("full_fwd_ready_after", int'(fwd_ready_o), 1);
    grad_data_i = 8'sd16;
    tick();
    check("same_pushpop_count", int'(mask_count_o), 15);
    check("same_pop_data", int'(out_data_o), pick(8'sd0, 8'sd2));
    fwd_valid_i  = 1'b0;
    grad_valid_i = 1'b0;

    // ---- clear flushes everything ----
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("flush_count", int'(mask_count_o), 0);
    check("flush_valid", int'(out_valid_o), 0);

    // ---- output back-pressure ----
    push(8'sd1);
    push(-8'sd1);
    push(8'sd2);
    push(8'sd3);
    out_ready_i  = 1'b0;
    grad_valid_i = 1'b1;
    grad_data_i  = 8'sd11;
    tick();
    check("bp_first_valid", int'(out_valid_o), 1);
    check("bp_first_data", int'(out_data_o), 11);
    grad_data_i = 8'sd22;
    for (int i = 0; i < 5; i++) begin
      check("bp_grad_ready", int'(grad_ready_o), 0);
      tick();
      check("bp_data_stable", int'(out_data_o), 11);
      check("bp_count_held", int'(mask_count_o), 3);
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_resume_1", int'(out_data_o), pick(8'sd0, 8'sd2));
    grad_data_i = 8'sd33;
    tick();
    check("bp_resume_2", int'(out_data_o), 33);
    grad_data_i = 8'sd44;
    tick();
    check("bp_resume_3", int'(out_data_o), 44);
    check("bp_resume_count", int'(mask_count_o), 0);
    grad_valid_i = 1'b0;
    tick();

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 8; i++) push(8'sd5);
    grad_valid_i = 1'b1;
    grad_data_i  = 8'sd7;
    tick();
    grad_valid_i = 1'b0;
    check("mid_count_7", int'(mask_count_o), 7);
    check("mid_valid", int'(out_valid_o), 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_count", int'(mask_count_o), 0);
    check("async_rst_valid", int'(out_valid_o), 0);
    check("async_rst_data",  int'(out_data_o), 0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // ---- synchronous clear mid-stream, with push and pop requested ----
    for (int i = 0; i < 8; i++) push(8'sd5);
    grad_valid_i = 1'b1;
    grad_data_i  = 8'sd7;
    tick();
    check("clr_pre_count", int'(mask_count_o), 7);
    fwd_valid_i = 1'b1;
    fwd_data_i  = 8'sd5;
    clear_i     = 1'b1;
    tick();
    clear_i      = 1'b0;
    fwd_valid_i  = 1'b0;
    grad_valid_i = 1'b0;
    check("clr_count", int'(mask_count_o), 0);
    check("clr_valid", int'(out_valid_o), 0);
    check("clr_grad_ready", int'(grad_ready_o), 0);

    // ---- ordering restarts cleanly after clear ----
    push(-8'sd5);
    grad_valid_i = 1'b1;
    grad_data_i  = 8'sd9;
    tick();
    grad_valid_i = 1'b0;
    check("after_clr_data", int'(out_data_o), pick(8'sd0, 8'sd1));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relu_backprop.md
RELU_BACKPROP -- requirements
Module: relu_backprop

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, width of signed activation and gradient words.
REQ-002 SHALL have parameter DEPTH, default 16, mask FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous flush of mask FIFO and output register.
REQ-006 SHALL have port fwd_valid_i  input  1  forward activation word valid.
REQ-007 SHALL have port fwd_ready_o  output  1  mask FIFO can accept an activation.
REQ-008 SHALL have port fwd_data_i  input  BITWIDTH  signed forward activation (pre-ReLU).
REQ-009 SHALL have port grad_valid_i  input  1  upstream gradient word valid.
REQ-010 SHALL have port grad_ready_o  output  1  gradient accepted this cycle.
REQ-011 SHALL have port grad_data_i  input  BITWIDTH  signed upstream gradient.
REQ-012 SHALL have port out_valid_o  output  1  out_data_o holds a result.
REQ-013 SHALL have port out_ready_i  input  1  downstream accepts the result.
REQ-014 SHALL have port out_data_o  output  BITWIDTH  signed masked gradient.
REQ-015 SHALL have port mask_count_o  output  $clog2(DEPTH)+1  stored mask bits.

Function
REQ-016 SHALL push one mask bit per forward transfer (fwd_valid_i and fwd_ready_o): 1 if fwd_data_i > 0 (sign bit 0 and nonzero), else 0; zero activation gives mask 0.
REQ-017 SHALL drive fwd_ready_o = (mask_count_o < DEPTH); no same-cycle bypass when full, even if a pop occurs.
REQ-018 SHALL drive grad_ready_o = (mask_count_o != 0) and (!out_valid_o or out_ready_i).
REQ-019 SHALL pop the oldest mask bit on each gradient transfer, strict FIFO order.
REQ-020 SHALL register the result on gradient transfer: out_data_o = grad_data_i if mask 1, else 0; latency exactly 1 cycle.
REQ-021 SHALL set out_valid_o the cycle after a gradient transfer and hold out_data_o stable until out_valid_o and out_ready_i.
REQ-022 SHALL clear out_valid_o after an output transfer unless a new gradient transfer occurs in that same cycle, which keeps it set and loads the new result.
REQ-023 SHALL leave mask_count_o unchanged on simultaneous push and pop, and otherwise increment on push or decrement on pop.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL, on clear_i, zero pointers, mask_count_o and out_valid_o next cycle; clear_i takes priority over same-cycle push and pop.

Reset
REQ-026 SHALL on rst_n_i low immediately force mask_count_o=0, out_valid_o=0, out_data_o=0 and both pointers to 0, including mid-stream.
REQ-027 SHALL present fwd_ready_o=1 and grad_ready_o=0 while in reset and on first cycle after release.

Configuration
REQ-028 SHALL, with macro RELU_BACKPROP_LEAKY_EN defined, output grad_data_i arithmetically shifted right by 3 (slope 1/8, sign kept) for mask-0 entries.
REQ-029 SHALL, without RELU_BACKPROP_LEAKY_EN, output 0 for mask-0 entries.

Verification
REQ-030 SHALL cover: push activations 5, -3, 0, 127; gradients 10,10,10,10 with out_ready_i=1 -> outputs 10,0,0,10, each 1 cycle after acceptance.
REQ-031 SHALL cover: push 16 activations -> fwd_ready_o=0, mask_count_o=16; simultaneous push and pop at full -> push refused, count 15.
REQ-032 SHALL cover: empty FIFO with grad_valid_i=1 -> grad_ready_o=0, out_valid_o stays 0.
REQ-033 SHALL cover: out_ready_i held 0 for 5 cycles -> out_data_o stable, grad_ready_o=0, no mask pop; release -> stream resumes in order.
REQ-034 SHALL cover: rst_n_i pulsed low with 7 entries mid-stream -> count 0, out_valid_o 0 immediately; clear_i gives same result synchronously.
REQ-035 SHALL cover: RELU_BACKPROP_LEAKY_EN defined, activation -4 then gradient -64 -> output -8; gradient 40 -> output 5.
